spi_turnaround_ctrl: RTL
========================

# spi_turnaround_ctrl

Parametrised SPI slave turnaround controller. It oversamples SPI_SYNC, SPI_CLK and SPI_MOSI in the Clock_108M domain and decodes read or write from a configurable command bit. On reads, it generates an early and a delayed active-low MISO output enable, with an optional automatic release after a fixed data length. It sits between the SPI pins and the MISO tri-state driver, and generalises the fixed 16-bit, rising-edge, single-delay enable logic.

## Interface
- CMD_LEN, 16: command bits per frame (1..2^CNT_W-1).
- RD_BIT_POS, 0: index (0 = first bit) of the read/write flag within the command.
- RD_POLARITY, 1: flag value meaning read.
- SAMPLE_EDGE, 0: 0 = sample on SPI_CLK rising edge, 1 = falling edge.
- DELAY_CLKS, 28: Clock_108M cycles between SPI_Out_EN and SPI_Out_EN2 falling; 0 allowed.
- DATA_LEN, 16: data bits driven before auto-release; 0 = drive until SPI_SYNC falls.
- SYNC_STAGES, 2: synchroniser depth on the three SPI inputs (≥2).
- CNT_W, 8: counter width.
- Clock_108M  in  1  system clock; the only clock.
- nReset  in  1  asynchronous, active-low reset.
- SPI_SYNC  in  1  frame select, high = frame active (asynchronous to the clock).
- SPI_CLK  in  1  SPI clock (asynchronous).
- SPI_MOSI  in  1  SPI data in (asynchronous).
- SPI_Out_EN  out  1  early enable, low = read turnaround started.
- SPI_Out_EN2  out  1  delayed enable, low = drive MISO.
- Frame_Is_Read  out  1  high from command decode until IDLE.
- Bit_Count  out  CNT_W  sample edges seen in the current frame, saturating.
- Frame_Done  out  1  one-cycle pulse when a non-IDLE frame ends.
- Frame_Short  out  1  one-cycle pulse when SPI_SYNC falls during CMD.

## Operation
- All three SPI inputs pass through SYNC_STAGES flops. A sample edge is detected from the last two synchronised SPI_CLK values, using the edge selected by SAMPLE_EDGE.
- States: IDLE, CMD, DELAY, DRIVE, HOLD.
- IDLE: on a synchronised SPI_SYNC rising edge, go to CMD. Clear Bit_Count, the flag and the counters.
- CMD: on each sample edge, Bit_Count increments. When the bit index equals RD_BIT_POS, latch MOSI into the flag.
  - On the CMD_LEN-th edge, if flag == RD_POLARITY, set Frame_Is_Read. Go to DELAY, or to DRIVE directly if DELAY_CLKS == 0.
  - Otherwise go to HOLD.
- DELAY: count Clock_108M cycles. After DELAY_CLKS cycles, go to DRIVE.
- DRIVE: count data sample edges. If DATA_LEN ≠ 0, go to HOLD on the DATA_LEN-th edge. If DATA_LEN = 0, stay in DRIVE.
- HOLD: both enables high; wait for SPI_SYNC low.
- Outputs by state:
  - SPI_Out_EN is low in DELAY and DRIVE, high otherwise.
  - SPI_Out_EN2 is low only in DRIVE.
  - SPI_Out_EN2 low implies SPI_Out_EN low.
- SPI_SYNC low (synchronised) in any non-IDLE state:
  - Go to IDLE next cycle; both enables high.
  - Pulse Frame_Done.
  - Also pulse Frame_Short if the state was CMD.
- Priority: SPI_SYNC low beats a simultaneous sample edge or delay expiry. The edge is ignored.
- Bit_Count counts command and data edges, saturates at 2^CNT_W-1, and holds its value in IDLE until the next frame starts.
- Sample edges in IDLE are ignored. A SPI_SYNC rising edge outside IDLE is impossible, because falling always returns the block to IDLE first.

## Timing
- Reset values:
  - State IDLE.
  - SPI_Out_EN = 1, SPI_Out_EN2 = 1.
  - Frame_Is_Read = 0, Bit_Count = 0, Frame_Done = 0, Frame_Short = 0.
  - Synchroniser flops = 0.
- Reset is asynchronous, so asserting it mid-frame releases MISO immediately.
- All outputs are registered.
- Pin edge to output change: SYNC_STAGES+1 clocks (±1 for the async sample phase).
- SPI_Out_EN falls SYNC_STAGES+1 clocks after the pin edge of the CMD_LEN-th sample.
- SPI_Out_EN2 falls exactly DELAY_CLKS clocks after SPI_Out_EN falls. When DELAY_CLKS == 0, both fall together.
- Auto-release: both enables rise SYNC_STAGES+1 clocks after the DATA_LEN-th data sample edge.
- SPI_CLK high and low phases must each be ≥ 2 Clock_108M periods (SPI_CLK ≤ 27 MHz). SPI_SYNC must be stable ≥ 2 clocks.

## Test plan
- Defaults; frame with first bit 1, 16 command bits at 10 MHz, then SYNC held -> SPI_Out_EN low 3±1 clocks after the 16th rising edge. SPI_Out_EN2 low 28 clocks later, rising 3±1 clocks after the 16th data edge. Bit_Count = 32.
- Defaults; first bit 0 -> both enables stay high for the whole frame. Frame_Is_Read = 0. Frame_Done pulses once after SYNC falls.
- CMD_LEN=8, RD_BIT_POS=7, RD_POLARITY=0, SAMPLE_EDGE=1, DELAY_CLKS=0, DATA_LEN=0 -> the 8th falling edge with MOSI=0 drives both enables low in the same cycle. They stay low until SYNC falls, then return high 3±1 clocks later.
- Defaults; SYNC drops after 9 command bits -> Frame_Short and Frame_Done pulse together. Enables never go low. The next frame decodes normally.
- Defaults; nReset asserted during DELAY, and separately during DRIVE -> enables high asynchronously in both cases. State returns to IDLE and Bit_Count = 0.
- CNT_W=4, DATA_LEN=0, 40 edges in a read frame -> Bit_Count saturates at 15. Enables stay low until SYNC falls.

Source files
------------

// File: rtl/spi_turnaround_ctrl.sv
// SPI slave MISO turnaround: oversamples the SPI pins, decodes the read flag
// and sequences the early/delayed active-low output enables.
module spi_turnaround_ctrl #(
    parameter int CMD_LEN     = 16,
    parameter int RD_BIT_POS  = 0,
    parameter bit RD_POLARITY = 1'b1,
    parameter int SAMPLE_EDGE = 0,
    parameter int DELAY_CLKS  = 28,
    parameter int DATA_LEN    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             Clock_108M,
    input  logic             nReset,
    input  logic             SPI_SYNC,
    input  logic             SPI_CLK,
    input  logic             SPI_MOSI,
    output logic             SPI_Out_EN,
    output logic             SPI_Out_EN2,
    output logic             Frame_Is_Read,
    output logic [CNT_W-1:0] Bit_Count,
    output logic             Frame_Done,
    output logic             Frame_Short
);

    localparam int M1   = (CMD_LEN > DELAY_CLKS) ? CMD_LEN : DELAY_CLKS;
    localparam int MAXV = (M1 > DATA_LEN) ? M1 : DATA_LEN;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0]    CMD_LAST  = CW'(CMD_LEN - 1);
    localparam logic [CW-1:0]    DLY_LAST  = CW'(DELAY_CLKS - 1);
    localparam logic [CW-1:0]    DATA_LAST = CW'(DATA_LEN - 1);
    localparam logic [CW-1:0]    RD_IDX    = CW'(RD_BIT_POS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {IDLE, CMD, DELAY, DRIVE, HOLD} state_t;

    logic [SYNC_STAGES-1:0] sync_sr, clk_sr, mosi_sr;
    logic                   sync_d, clk_d;
    logic                   sync_s, clk_s, mosi_s;
    logic                   sync_rise, sample;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               flag, flag_n, flag_now;
    logic               read_n;
    logic [CNT_W-1:0]   bc_n, bc_inc;
    logic               done_n, short_n;
    logic               en_n, en2_n;

    assign sync_s    = sync_sr[SYNC_STAGES-1];
    assign clk_s     = clk_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sync_rise = sync_s & ~sync_d;
    assign sample    = (SAMPLE_EDGE != 0) ? (clk_d & ~clk_s)
                                          : (clk_s & ~clk_d);

    // The flag bit may be the last command bit, so decode uses it directly.
    assign flag_now = (cnt == RD_IDX) ? mosi_s : flag;
    assign bc_inc   = (Bit_Count == CNT_MAX) ? Bit_Count
                                             : Bit_Count + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        flag_n  = flag;
        read_n  = Frame_Is_Read;
        bc_n    = Bit_Count;
        done_n  = 1'b0;
        short_n = 1'b0;
        if (state != IDLE && !sync_s) begin
            state_n = IDLE;
            read_n  = 1'b0;
            done_n  = 1'b0 | 1'b1;
            short_n = (state == CMD);
        end else begin
            unique case (state)
                IDLE: begin
                    if (sync_rise) begin
                        state_n = CMD;
                        cnt_n   = '0;
                        flag_n  = 1'b0;
                        read_n  = 1'b0;
                        bc_n    = '0;
                    end
                end
                CMD: begin
                    if (sample) begin
                        bc_n  = bc_inc;
                        cnt_n = cnt + 1'b1;
                        if (cnt == RD_IDX) flag_n = mosi_s;
                        if (cnt == CMD_LAST) begin
                            cnt_n = '0;
                            if (flag_now == RD_POLARITY) begin
                                read_n  = 1'b1;
                                state_n = (DELAY_CLKS == 0) ? DRIVE : DELAY;
                            end else begin
                                state_n = HOLD;
                            end
                        end
                    end
                end
                DELAY: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == DLY_LAST) begin
                        cnt_n   = '0;
                        state_n = DRIVE;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        bc_n = bc_inc;
                        if (DATA_LEN != 0) begin
                            cnt_n = cnt + 1'b1;
                            if (cnt == DATA_LAST) state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                end
                default: state_n = IDLE;
            endcase
        end
        en_n  = !(state_n == DELAY || state_n == DRIVE);
        en2_n = (state_n != DRIVE);
    end

    always_ff @(posedge Clock_108M or negedge nReset) begin
        if (!nReset) begin
            sync_sr       <= '0;
            clk_sr        <= '0;
            mosi_sr       <= '0;
            sync_d        <= 1'b0;
            clk_d         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            flag          <= 1'b0;
            Frame_Is_Read <= 1'b0;
            Bit_Count     <= '0;
            Frame_Done    <= 1'b0;
            Frame_Short   <= 1'b0;
            SPI_Out_EN    <= 1'b1;
            SPI_Out_EN2   <= 1'b1;
        end else begin
            sync_sr       <= {sync_sr[SYNC_STAGES-2:0], SPI_SYNC};
            clk_sr        <= {clk_sr[SYNC_STAGES-2:0], SPI_CLK};
            mosi_sr       <= {mosi_sr[SYNC_STAGES-2:0], SPI_MOSI};
            sync_d        <= sync_s;
            clk_d         <= clk_s;
            state         <= state_n;
            cnt           <= cnt_n;
            flag          <= flag_n;
            Frame_Is_Read <= read_n;
            Bit_Count     <= bc_n;
            Frame_Done    <= done_n;
            Frame_Short   <= short_n;
            SPI_Out_EN    <= en_n;
            SPI_Out_EN2   <= en2_n;
        end
    end

endmodule
